// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer.
// Handles csrrw/csrrs, ecall and mret with valid/ready on both sides.
module csr_trap_unit #(
  parameter logic [31:0] MARCHID = 32'h0,
  parameter logic [31:0] MVENDOR = 32'h79737978
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] csr_addr,
  input  logic [31:0] src,
  input  logic        csr_we,
  input  logic        csr_set,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic        redirect,
  output logic [31:0] target,
  output logic        illegal
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [31:0] MPP = 32'h0000_1800;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mstatus;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [31:0] r_rdata;
  logic [31:0] r_target;
  logic        r_redirect;
  logic        r_illegal;

  logic [31:0] w_mstatus;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_known;
  logic        w_ro;
  logic        w_trap;
  logic        w_ill;
  logic        w_wr;
  logic        w_accept;

  assign w_mstatus = r_mstatus | MPP;
  assign w_new     = csr_set ? (w_old | src) : src;
  assign w_trap    = is_ecall | is_mret;
  assign w_ill     = !w_trap && (!w_known || (csr_we && w_ro));
  assign w_wr      = !w_trap && csr_we && !w_ill;
  assign w_accept  = in_valid && in_ready;

  assign rdata    = r_rdata;
  assign target   = r_target;
  assign redirect = r_redirect;
  assign illegal  = r_illegal;

  // Address decode: current value, known and read-only flags
  always_comb begin
    w_old   = '0;
    w_known = 1'b1;
    w_ro    = 1'b0;
    case (csr_addr)
      12'h300: w_old = w_mstatus;
      12'h305: w_old = r_mtvec;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'hB00: begin w_old = r_mcycle[31:0];  w_ro = 1'b1; end
      12'hB80: begin w_old = r_mcycle[63:32]; w_ro = 1'b1; end
      12'hF11: begin w_old = MVENDOR;         w_ro = 1'b1; end
      12'hF12: begin w_old = MARCHID;         w_ro = 1'b1; end
      default: w_known = 1'b0;
    endcase
  end

  // Handshake FSM next state and status outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Free-running cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mcycle <= '0;
    else        r_mcycle <= r_mcycle + 64'd1;
  end

  // Commit CSR/trap effects and latch results at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus  <= MPP;
      r_mtvec    <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_rdata    <= '0;
      r_target   <= '0;
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_redirect <= w_trap;
      r_illegal  <= w_ill;
      if (is_ecall) begin
        r_mepc       <= pc;
        r_mcause     <= 32'd11;
        r_mstatus[7] <= r_mstatus[3];
        r_mstatus[3] <= 1'b0;
        r_target     <= r_mtvec;
        r_rdata      <= '0;
      end else if (is_mret) begin
        r_mstatus[3] <= r_mstatus[7];
        r_mstatus[7] <= 1'b1;
        r_target     <= r_mepc;
        r_rdata      <= '0;
      end else begin
        r_target <= '0;
        r_rdata  <= w_ill ? 32'd0 : w_old;
        if (w_wr) begin
          case (csr_addr)
            12'h300: r_mstatus <= w_new | MPP;
            12'h305: r_mtvec   <= w_new;
            12'h341: r_mepc    <= w_new;
            12'h342: r_mcause  <= w_new;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit.
// Each task drives one scenario and checks results inline.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] csr_addr = '0;
  logic [31:0] src = '0;
  logic        csr_we = 1'b0;
  logic        csr_set = 1'b0;
  logic        is_ecall = 1'b0;
  logic        is_mret = 1'b0;
  logic [31:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] target;
  logic        illegal;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] o_rd;
  logic [31:0] o_tgt;
  logic        o_redir;
  logic        o_ill;
  logic        o_ov;

  csr_trap_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .csr_addr(csr_addr), .src(src),
    .csr_we(csr_we), .csr_set(csr_set),
    .is_ecall(is_ecall), .is_mret(is_mret),
    .pc(pc), .out_valid(out_valid),
    .out_ready(out_ready), .rdata(rdata),
    .redirect(redirect), .target(target),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // One full transaction: drive, accept, capture at negedge, drain.
  task automatic op(input logic [11:0] a, input logic [31:0] s,
                    input logic we, input logic st,
                    input logic ec, input logic mr,
                    input logic [31:0] p);
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) begin
      $display("FAIL op_ready: got %b want 1", in_ready);
      n_fail++;
    end
    csr_addr = a; src = s; csr_we = we; csr_set = st;
    is_ecall = ec; is_mret = mr; pc = p;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    csr_we = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    @(negedge clk);
    o_rd = rdata; o_tgt = target; o_redir = redirect;
    o_ill = illegal; o_ov = out_valid;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    op(a, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rst_in_ready: got %b want 1", in_ready); n_fail++;
    end
    n_chk++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_out_valid: got %b want 0", out_valid); n_fail++;
    end
    n_chk++;
    if (redirect !== 1'b0 || illegal !== 1'b0) begin
      $display("FAIL rst_flags: got %b%b want 00", redirect, illegal);
      n_fail++;
    end
    n_chk++;
    if (rdata !== 32'h0 || target !== 32'h0) begin
      $display("FAIL rst_data: got %h/%h want 0/0", rdata, target);
      n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h0000_1800) begin
      $display("FAIL rst_mstatus: got %h want 00001800", o_rd); n_fail++;
    end
    n_chk++;
    if (o_ov !== 1'b1 || o_ill !== 1'b0) begin
      $display("FAIL rst_rd_flags: got %b%b want 10", o_ov, o_ill);
      n_fail++;
    end
  endtask

  task automatic test_csrrw();
    op(12'h305, 32'h8000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_rd !== 32'h0 || o_redir !== 1'b0 || o_ill !== 1'b0) begin
      $display("FAIL csrrw_mtvec: got %h %b%b want 0 00",
               o_rd, o_redir, o_ill);
      n_fail++;
    end
    op(12'h305, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_rd !== 32'h8000_0100) begin
      $display("FAIL csrrs0_mtvec: got %h want 80000100", o_rd); n_fail++;
    end
    rd(12'h305);
    n_chk++;
    if (o_rd !== 32'h8000_0100) begin
      $display("FAIL mtvec_kept: got %h want 80000100", o_rd); n_fail++;
    end
  endtask

  task automatic test_ecall();
    op(12'h300, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_rd !== 32'h1800) begin
      $display("FAIL csrrs_mst_old: got %h want 1800", o_rd); n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1808) begin
      $display("FAIL csrrs_mst_new: got %h want 1808", o_rd); n_fail++;
    end
    op(12'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0040);
    n_chk++;
    if (o_redir !== 1'b1 || o_tgt !== 32'h8000_0100 || o_rd !== 0) begin
      $display("FAIL ecall_out: got %b %h %h want 1 80000100 0",
               o_redir, o_tgt, o_rd);
      n_fail++;
    end
    rd(12'h341);
    n_chk++;
    if (o_rd !== 32'h8000_0040) begin
      $display("FAIL ecall_mepc: got %h want 80000040", o_rd); n_fail++;
    end
    rd(12'h342);
    n_chk++;
    if (o_rd !== 32'd11) begin
      $display("FAIL ecall_mcause: got %h want b", o_rd); n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1880) begin
      $display("FAIL ecall_mstatus: got %h want 1880", o_rd); n_fail++;
    end
  endtask

  task automatic test_mret();
    op(12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    n_chk++;
    if (o_redir !== 1'b1 || o_tgt !== 32'h8000_0040 || o_rd !== 0) begin
      $display("FAIL mret_out: got %b %h %h want 1 80000040 0",
               o_redir, o_tgt, o_rd);
      n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1888) begin
      $display("FAIL mret_mstatus: got %h want 1888", o_rd); n_fail++;
    end
  endtask

  task automatic test_illegal();
    op(12'hF11, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_ill !== 1'b1 || o_rd !== 32'h0 || o_redir !== 1'b0) begin
      $display("FAIL ill_rw_ro: got %b %h want 1 0", o_ill, o_rd);
      n_fail++;
    end
    op(12'hF11, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_ill !== 1'b1 || o_rd !== 32'h0) begin
      $display("FAIL ill_rs0_ro: got %b %h want 1 0", o_ill, o_rd);
      n_fail++;
    end
    rd(12'h7C0);
    n_chk++;
    if (o_ill !== 1'b1 || o_rd !== 32'h0) begin
      $display("FAIL ill_unknown: got %b %h want 1 0", o_ill, o_rd);
      n_fail++;
    end
    op(12'h7C0, 32'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_ill !== 1'b1) begin
      $display("FAIL ill_unknown_wr: got %b want 1", o_ill); n_fail++;
    end
    rd(12'hF11);
    n_chk++;
    if (o_ill !== 1'b0 || o_rd !== 32'h7973_7978) begin
      $display("FAIL mvendorid: got %b %h want 0 79737978", o_ill, o_rd);
      n_fail++;
    end
    rd(12'hF12);
    n_chk++;
    if (o_ill !== 1'b0 || o_rd !== 32'h0) begin
      $display("FAIL marchid: got %b %h want 0 0", o_ill, o_rd);
      n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1888) begin
      $display("FAIL ill_nochange: got %h want 1888", o_rd); n_fail++;
    end
  endtask

  task automatic test_priority();
    op(12'h305, 32'hDEAD, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
    n_chk++;
    if (o_redir !== 1'b1 || o_tgt !== 32'h8000_0100 || o_ill !== 0) begin
      $display("FAIL prio_ecall_we: got %b %h want 1 80000100",
               o_redir, o_tgt);
      n_fail++;
    end
    rd(12'h305);
    n_chk++;
    if (o_rd !== 32'h8000_0100) begin
      $display("FAIL prio_we_drop: got %h want 80000100", o_rd); n_fail++;
    end
    op(12'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    n_chk++;
    if (o_tgt !== 32'h8000_0100) begin
      $display("FAIL prio_ecall_mret: got %h want 80000100", o_tgt);
      n_fail++;
    end
    rd(12'h341);
    n_chk++;
    if (o_rd !== 32'h200) begin
      $display("FAIL prio_mepc: got %h want 200", o_rd); n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1800) begin
      $display("FAIL prio_mstatus: got %h want 1800", o_rd); n_fail++;
    end
    op(12'h300, 32'h88, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1888) begin
      $display("FAIL mpp_sticky: got %h want 1888", o_rd); n_fail++;
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    csr_addr = 12'h305; csr_we = 1'b0; csr_set = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL hold_hs[%0d]: got %b%b want 10",
                 i, out_valid, in_ready);
        n_fail++;
      end
      n_chk++;
      if (rdata !== 32'h8000_0100 || target !== 32'h0) begin
        $display("FAIL hold_data[%0d]: got %h %h want 80000100 0",
                 i, rdata, target);
        n_fail++;
      end
      csr_addr = 12'h300; src = 32'hFFFF_FFFF;
      csr_we = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; csr_we = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL hold_release: got %b%b want 10", in_ready, out_valid);
      n_fail++;
    end
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1888) begin
      $display("FAIL hold_ignored: got %h want 1888", o_rd); n_fail++;
    end
  endtask

  task automatic test_mcycle();
    @(negedge clk);
    force dut.r_mcycle = 64'hFFFF_FFFF_FFFF_FFFD;
    release dut.r_mcycle;
    rd(12'hB80);
    n_chk++;
    if (o_rd !== 32'hFFFF_FFFF || o_ill !== 1'b0) begin
      $display("FAIL mcycleh_top: got %h want ffffffff", o_rd); n_fail++;
    end
    rd(12'hB00);
    n_chk++;
    if (o_rd !== 32'h0) begin
      $display("FAIL mcycle_wrap: got %h want 0", o_rd); n_fail++;
    end
    rd(12'hB80);
    n_chk++;
    if (o_rd !== 32'h0) begin
      $display("FAIL mcycleh_wrap: got %h want 0", o_rd); n_fail++;
    end
    @(negedge clk);
    force dut.r_mcycle = 64'h0000_0000_FFFF_FFFD;
    release dut.r_mcycle;
    rd(12'hB80);
    n_chk++;
    if (o_rd !== 32'h0) begin
      $display("FAIL mcycleh_pre: got %h want 0", o_rd); n_fail++;
    end
    rd(12'hB00);
    n_chk++;
    if (o_rd !== 32'h0) begin
      $display("FAIL mcycle_carry_lo: got %h want 0", o_rd); n_fail++;
    end
    rd(12'hB80);
    n_chk++;
    if (o_rd !== 32'h1) begin
      $display("FAIL mcycle_carry_hi: got %h want 1", o_rd); n_fail++;
    end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    csr_addr = 12'h305; csr_we = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1) begin
      $display("FAIL rh_pre: got %b want 1", out_valid); n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rdata !== 0) begin
      $display("FAIL rh_async: got %b%b %h want 10 0",
               out_valid, in_ready, rdata);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'h300);
    n_chk++;
    if (o_rd !== 32'h1800) begin
      $display("FAIL rh_mstatus: got %h want 1800", o_rd); n_fail++;
    end
    rd(12'h305);
    n_chk++;
    if (o_rd !== 32'h0) begin
      $display("FAIL rh_mtvec: got %h want 0", o_rd); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_ecall();
    test_mret();
    test_illegal();
    test_priority();
    test_hold();
    test_mcycle();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
